noc_pe_iface: RTL and testbench
===============================

NOC_PE_IFACE -- requirements
Module: noc_pe_iface

Interface
REQ-001 Parameter X, 2, mesh columns.
REQ-002 Parameter Y, 2, mesh rows.
REQ-003 Parameter x_coord, 0, own column.
REQ-004 Parameter y_coord, 0, own row.
REQ-005 Parameter data_width, 32, payload bits.
REQ-006 Parameter x_size, 1, X-field bits.
REQ-007 Parameter y_size, 1, Y-field bits.
REQ-008 Parameter total_width, x_size+y_size+data_width, flit bits.
REQ-009 Parameter TX_DEPTH, 4, TX FIFO entries; power of 2, at least 2.
REQ-010 Parameter RX_DEPTH, 8, RX FIFO entries; power of 2, at least 2.
REQ-011 Flit layout SHALL be: [x_size-1:0] dest X; [x_size+y_size-1:x_size] dest Y; [total_width-1:x_size+y_size] payload.
REQ-012 clk  in  1  clock; rstn  in  1  reset, synchronous, active-low.
REQ-013 s_valid  in  1  PE TX flit valid.
REQ-014 s_ready  out  1  TX FIFO can accept.
REQ-015 s_data  in  data_width  TX payload.
REQ-016 s_dest_x  in  x_size  destination column.
REQ-017 s_dest_y  in  y_size  destination row.
REQ-018 o_valid_sw  out  1  flit to switch PE input.
REQ-019 i_ready_sw  in  1  switch accepts PE flit.
REQ-020 o_data_sw  out  total_width  flit to switch.
REQ-021 i_valid_sw  in  1  flit from switch PE output; no backpressure.
REQ-022 i_data_sw  in  total_width  flit from switch.
REQ-023 m_valid  out  1  RX payload valid; m_ready  in  1  PE accepts.
REQ-024 m_data  out  data_width  RX payload.
REQ-025 o_overflow  out  1  sticky RX drop flag.
REQ-026 o_drop_cnt  out  16  RX overflow drops; o_misroute_cnt  out  16  misrouted drops.

Function
REQ-027 TX write: s_valid & s_ready SHALL push {s_data, s_dest_y, s_dest_x} into the TX FIFO.
REQ-028 s_ready SHALL be asserted iff the TX occupancy register is below TX_DEPTH.
REQ-029 A push at full SHALL NOT be accepted, even when a pop occurs in the same cycle.
REQ-030 o_valid_sw SHALL equal TX not-empty; o_data_sw SHALL be the head entry.
REQ-031 o_valid_sw SHALL NOT depend combinationally on i_ready_sw.
REQ-032 A TX pop SHALL occur iff o_valid_sw & i_ready_sw.
REQ-033 o_data_sw SHALL hold stable while o_valid_sw=1 and i_ready_sw=0.
REQ-034 TX latency: a flit accepted at edge N SHALL appear on o_valid_sw after edge N (cycle N+1) when the FIFO was empty.
REQ-035 Back-to-back TX transfers SHALL sustain 1 flit/cycle while i_ready_sw=1.
REQ-036 An RX flit with i_valid_sw=1 whose dest fields do not equal (x_coord, y_coord) SHALL be dropped.
REQ-037 Each such misrouted drop SHALL increment o_misroute_cnt, saturating at 16'hFFFF.
REQ-038 An RX flit with i_valid_sw=1 and matching dest SHALL push its payload into the RX FIFO if space exists.
REQ-039 RX space SHALL count as available when the RX FIFO is not full, or when it is full and m_valid & m_ready pops in the same cycle.
REQ-040 A matching RX flit arriving with no space SHALL be dropped.
REQ-041 Each overflow drop SHALL set o_overflow and increment o_drop_cnt, saturating at 16'hFFFF.
REQ-042 m_valid SHALL equal RX not-empty; m_data SHALL be the head payload.
REQ-043 An RX pop SHALL occur iff m_valid & m_ready; m_data SHALL hold stable while stalled.
REQ-044 RX latency: a flit arriving at edge N SHALL give m_valid=1 in cycle N+1.
REQ-045 Both FIFOs SHALL use binary read/write pointers that wrap modulo depth, plus occupancy counters of width clog2(depth)+1.
REQ-046 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-047 Each FIFO SHALL preserve arrival order.

Reset
REQ-048 While rstn=0 at an edge: both FIFOs SHALL be emptied (pointers, counts = 0); o_valid_sw=0, m_valid=0, s_ready=0, o_overflow=0, o_drop_cnt=0, o_misroute_cnt=0.
REQ-049 Flits in flight when reset is asserted SHALL be discarded.
REQ-050 s_ready SHALL become 1 in the first cycle after rstn returns high.
REQ-051 FIFO storage arrays SHALL require no reset.

Verification
REQ-052 TX: after reset, push 0xA5A5A5A5 to (1,0) with i_ready_sw=1 -> o_data_sw={0xA5A5A5A5,1'b0,1'b1} at N+1, one cycle only.
REQ-053 TX backpressure: i_ready_sw=0, push 5 flits -> 4 accepted, s_ready=0, o_data_sw stable; release -> 4 flits in order, then o_valid_sw=0.
REQ-054 RX: 3 flits to (0,0), m_ready=1 -> m_data sequence identical, each one cycle after arrival.
REQ-055 RX overflow: m_ready=0, 10 matching flits -> 8 buffered, o_drop_cnt=2, o_overflow=1; drain -> first 8 payloads in order.
REQ-056 Full RX plus same-cycle pop and arrival -> arrival accepted, o_drop_cnt unchanged.
REQ-057 Misroute flit to (1,1) -> m_valid stays 0, o_misroute_cnt=1; reset mid-traffic -> all outputs per REQ-048.

Source files
------------

// File: rtl/noc_pe_iface.sv
// Network-on-chip processing-element interface: a TX FIFO from the PE to the switch
// and an RX FIFO from the switch to the PE, with filtering of misrouted and overflowing flits.
module noc_pe_iface #(
   parameter int unsigned X           = 2,
   parameter int unsigned Y           = 2,
   parameter int unsigned x_coord     = 0,
   parameter int unsigned y_coord     = 0,
   parameter int unsigned data_width  = 32,
   parameter int unsigned x_size      = 1,
   parameter int unsigned y_size      = 1,
   parameter int unsigned total_width = x_size + y_size + data_width,
   parameter int unsigned TX_DEPTH    = 4,
   parameter int unsigned RX_DEPTH    = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [data_width-1:0]  s_data,
   input  logic [x_size-1:0]      s_dest_x,
   input  logic [y_size-1:0]      s_dest_y,
   output logic                   o_valid_sw,
   input  logic                   i_ready_sw,
   output logic [total_width-1:0] o_data_sw,
   input  logic                   i_valid_sw,
   input  logic [total_width-1:0] i_data_sw,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [data_width-1:0]  m_data,
   output logic                   o_overflow,
   output logic [15:0]            o_drop_cnt,
   output logic [15:0]            o_misroute_cnt
);

   localparam int unsigned HDR_W = x_size + y_size;
   localparam int unsigned TX_AW = $clog2(TX_DEPTH);
   localparam int unsigned TX_CW = TX_AW + 1;
   localparam int unsigned RX_AW = $clog2(RX_DEPTH);
   localparam int unsigned RX_CW = RX_AW + 1;

   // Reject parameter sets the pointer arithmetic and flit layout cannot support
   if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx_depth
      $error("TX_DEPTH must be a power of 2 and at least 2");
   end
   if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx_depth
      $error("RX_DEPTH must be a power of 2 and at least 2");
   end
   if (x_coord >= X || y_coord >= Y) begin : g_bad_coord
      $error("own coordinates lie outside the mesh");
   end
   if (total_width != HDR_W + data_width) begin : g_bad_width
      $error("total_width must equal x_size + y_size + data_width");
   end

   logic [total_width-1:0] tx_mem [TX_DEPTH];
   logic [data_width-1:0]  rx_mem [RX_DEPTH];

   logic             live_q;
   logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [15:0]      drop_q, drop_d, misr_q, misr_d;
   logic             ovf_q, ovf_d;

   logic tx_push, tx_pop, rx_push, rx_pop, rx_match, rx_space;

   assign s_ready        = live_q && (tx_cnt_q < TX_CW'(TX_DEPTH));
   assign o_valid_sw     = (tx_cnt_q != '0);
   assign o_data_sw      = tx_mem[tx_rd_q];
   assign m_valid        = (rx_cnt_q != '0);
   assign m_data         = rx_mem[rx_rd_q];
   assign o_overflow     = ovf_q;
   assign o_drop_cnt     = drop_q;
   assign o_misroute_cnt = misr_q;

   assign tx_push  = s_valid && s_ready;
   assign tx_pop   = o_valid_sw && i_ready_sw;
   assign rx_pop   = m_valid && m_ready;
   assign rx_match = (i_data_sw[x_size-1:0] == x_size'(x_coord)) &&
                     (i_data_sw[HDR_W-1:x_size] == y_size'(y_coord));
   // A full RX FIFO still has room when its head leaves in the same cycle
   assign rx_space = (rx_cnt_q != RX_CW'(RX_DEPTH)) || rx_pop;
   assign rx_push  = i_valid_sw && rx_match && rx_space;

   always_comb begin
      tx_wr_d  = tx_wr_q;
      tx_rd_d  = tx_rd_q;
      tx_cnt_d = tx_cnt_q;
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      rx_cnt_d = rx_cnt_q;
      drop_d   = drop_q;
      misr_d   = misr_q;
      ovf_d    = ovf_q;

      if (tx_push) tx_wr_d = tx_wr_q + TX_AW'(1);
      if (tx_pop)  tx_rd_d = tx_rd_q + TX_AW'(1);
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + TX_CW'(1);
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TX_CW'(1);

      if (rx_push) rx_wr_d = rx_wr_q + RX_AW'(1);
      if (rx_pop)  rx_rd_d = rx_rd_q + RX_AW'(1);
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + RX_CW'(1);
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RX_CW'(1);

      if (i_valid_sw && !rx_match && misr_q != 16'hFFFF) misr_d = misr_q + 16'd1;
      if (i_valid_sw && rx_match && !rx_space) begin
         ovf_d = 1'b1;
         if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         live_q   <= 1'b0;
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
         drop_q   <= '0;
         misr_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         live_q   <= 1'b1;
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         tx_cnt_q <= tx_cnt_d;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         rx_cnt_q <= rx_cnt_d;
         drop_q   <= drop_d;
         misr_q   <= misr_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is never reset; the pointers alone define what is valid
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_q] <= {s_data, s_dest_y, s_dest_x};
      if (rx_push) rx_mem[rx_wr_q] <= i_data_sw[total_width-1:HDR_W];
   end

endmodule

// File: tb/tb_noc_pe_iface.sv
// Directed bench for noc_pe_iface at default parameters (own node (0,0), TX depth 4, RX depth 8).
module tb_noc_pe_iface;

   logic        clk = 1'b0;
   logic        rstn;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic [0:0]  s_dest_x;
   logic [0:0]  s_dest_y;
   logic        o_valid_sw;
   logic        i_ready_sw;
   logic [33:0] o_data_sw;
   logic        i_valid_sw;
   logic [33:0] i_data_sw;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        o_overflow;
   logic [15:0] o_drop_cnt;
   logic [15:0] o_misroute_cnt;

   int n_checks = 0;
   int n_errors = 0;

   noc_pe_iface dut (
      .clk(clk), .rstn(rstn),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_dest_x(s_dest_x), .s_dest_y(s_dest_y),
      .o_valid_sw(o_valid_sw), .i_ready_sw(i_ready_sw), .o_data_sw(o_data_sw),
      .i_valid_sw(i_valid_sw), .i_data_sw(i_data_sw),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt), .o_misroute_cnt(o_misroute_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one edge, then settle so inputs and samples sit away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [33:0] flit(input logic [31:0] d, input logic y, input logic x);
      return {d, y, x};
   endfunction

   task automatic check_reset_state(input string pfx);
      check({pfx, "_o_valid_sw"}, 64'(o_valid_sw), 64'd0);
      check({pfx, "_m_valid"},    64'(m_valid),    64'd0);
      check({pfx, "_s_ready"},    64'(s_ready),    64'd0);
      check({pfx, "_overflow"},   64'(o_overflow), 64'd0);
      check({pfx, "_drop_cnt"},   64'(o_drop_cnt), 64'd0);
      check({pfx, "_misr_cnt"},   64'(o_misroute_cnt), 64'd0);
   endtask

   initial begin
      rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_dest_x = '0; s_dest_y = '0;
      i_ready_sw = 1'b0; i_valid_sw = 1'b0; i_data_sw = '0; m_ready = 1'b0;
      #1;
      repeat (3) tick();
      check_reset_state("rst");
      rstn = 1'b1;
      tick();
      check("rdy_after_rst", 64'(s_ready), 64'd1);

      // Single TX flit visible for exactly one cycle
      i_ready_sw = 1'b1;
      s_valid = 1'b1; s_data = 32'hA5A5A5A5; s_dest_x = 1'b1; s_dest_y = 1'b0;
      check("tx1_empty_before", 64'(o_valid_sw), 64'd0);
      tick();
      s_valid = 1'b0;
      check("tx1_valid", 64'(o_valid_sw), 64'd1);
      check("tx1_data",  64'(o_data_sw), 64'({32'hA5A5A5A5, 1'b0, 1'b1}));
      tick();
      check("tx1_gone", 64'(o_valid_sw), 64'd0);

      // TX backpressure: only four of five flits fit
      i_ready_sw = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1; s_data = 32'h100 + 32'(i);
         s_dest_x = 1'(i); s_dest_y = 1'(i >> 1);
         check($sformatf("bp_s_ready_%0d", i), 64'(s_ready), (i < 4) ? 64'd1 : 64'd0);
         tick();
      end
      s_valid = 1'b0;
      check("bp_full_ready", 64'(s_ready), 64'd0);
      for (int k = 0; k < 2; k++) begin
         check("bp_stall_valid", 64'(o_valid_sw), 64'd1);
         check("bp_stall_data",  64'(o_data_sw), 64'(flit(32'h100, 1'b0, 1'b0)));
         tick();
      end
      i_ready_sw = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("bp_drain_valid_%0d", i), 64'(o_valid_sw), 64'd1);
         check($sformatf("bp_drain_data_%0d", i), 64'(o_data_sw),
               64'(flit(32'h100 + 32'(i), 1'(i >> 1), 1'(i))));
         tick();
      end
      check("bp_drained", 64'(o_valid_sw), 64'd0);

      // RX pass-through, one cycle after arrival, back to back
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_valid_sw = 1'b1; i_data_sw = flit(32'hC0DE0000 + 32'(i), 1'b0, 1'b0);
         tick();
         check($sformatf("rx_valid_%0d", i), 64'(m_valid), 64'd1);
         check($sformatf("rx_data_%0d", i),  64'(m_data), 64'(32'hC0DE0000 + 32'(i)));
      end
      i_valid_sw = 1'b0;
      tick();
      check("rx_empty", 64'(m_valid), 64'd0);

      // RX overflow: 10 arrivals into an 8-deep FIFO
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         i_valid_sw = 1'b1; i_data_sw = flit(32'hD000 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      i_valid_sw = 1'b0;
      check("ovf_drop_cnt", 64'(o_drop_cnt), 64'd2);
      check("ovf_flag",     64'(o_overflow), 64'd1);
      check("ovf_misr_cnt", 64'(o_misroute_cnt), 64'd0);
      check("ovf_head",     64'(m_data), 64'(32'hD000));

      // Full FIFO, pop and arrival on the same edge: arrival kept
      m_ready = 1'b1;
      i_valid_sw = 1'b1; i_data_sw = flit(32'h0000E0E0, 1'b0, 1'b0);
      tick();
      i_valid_sw = 1'b0;
      check("full_pop_push_drop", 64'(o_drop_cnt), 64'd2);
      for (int i = 1; i < 8; i++) begin
         check($sformatf("ovf_drain_%0d", i), 64'(m_data), 64'(32'hD000 + 32'(i)));
         tick();
      end
      check("ovf_drain_tail_valid", 64'(m_valid), 64'd1);
      check("ovf_drain_tail", 64'(m_data), 64'(32'h0000E0E0));
      tick();
      check("ovf_drained", 64'(m_valid), 64'd0);
      check("ovf_sticky", 64'(o_overflow), 64'd1);

      // Misrouted flits are counted and never reach the PE
      i_valid_sw = 1'b1; i_data_sw = flit(32'hBAD0BAD0, 1'b1, 1'b1);
      tick();
      i_valid_sw = 1'b0;
      check("misr1_m_valid", 64'(m_valid), 64'd0);
      check("misr1_cnt", 64'(o_misroute_cnt), 64'd1);
      i_valid_sw = 1'b1; i_data_sw = flit(32'hBAD1BAD1, 1'b0, 1'b1);
      tick();
      i_valid_sw = 1'b0;
      check("misr2_m_valid", 64'(m_valid), 64'd0);
      check("misr2_cnt", 64'(o_misroute_cnt), 64'd2);
      check("misr_drop_cnt", 64'(o_drop_cnt), 64'd2);

      // Reset with traffic pending in both directions
      i_ready_sw = 1'b0; m_ready = 1'b0;
      s_valid = 1'b1; s_data = 32'h77; s_dest_x = 1'b1; s_dest_y = 1'b1;
      i_valid_sw = 1'b1; i_data_sw = flit(32'h88, 1'b0, 1'b0);
      tick();
      s_valid = 1'b0; i_valid_sw = 1'b0;
      check("mid_tx_pending", 64'(o_valid_sw), 64'd1);
      check("mid_rx_pending", 64'(m_valid), 64'd1);
      rstn = 1'b0;
      tick();
      check_reset_state("mid_rst");
      rstn = 1'b1;
      tick();
      check("post_rst_ready", 64'(s_ready), 64'd1);
      check("post_rst_tx", 64'(o_valid_sw), 64'd0);
      check("post_rst_rx", 64'(m_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
